// File: rtl/mps_pkg.sv
// ---------------------------------------------------------------------------
// mps_pkg
// Shared definitions for the instruction fetch unit: data/address widths,
// the default reset fetch address, the fetch FSM state type, the prefetch
// entry layout and a word-alignment helper.
// ---------------------------------------------------------------------------
package mps_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IDLE : no request outstanding
    // REQ  : request outstanding, its response will be kept
    // DRAIN: request outstanding, its response will be thrown away
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DRAIN
    } fetch_state_e;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Prefetch FIFO of DEPTH entries (power of two, 2..16), WIDTH bits each.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   push, push_data     write one entry (ignored when full unless popping)
//   pop                 discard the head entry (ignored when empty)
//   flush               empty the FIFO; wins over push and pop
//   head_data           head entry, forced to zero while empty
//   full, empty, count  occupancy, all derived from registered state
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale contents are never visible
    // because the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction prefetch unit: issues sequential word reads to instruction
// memory (one outstanding at a time), buffers the responses in a DEPTH-entry
// FIFO and presents them to the CPU with valid/ready handshaking. A redirect
// flushes everything and restarts fetching at redirect_pc (word-aligned);
// a response already in flight is dropped.
// Optional feature: define IFETCH_BYPASS_EN to let a response arriving while
// the FIFO is empty and the CPU is ready go straight to instr/pc/valid in the
// mem_ack cycle without being written into the FIFO.
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   mem_req, mem_addr        memory read request and word-aligned address
//   mem_ack, mem_rdata       one-cycle response strobe and read data
//   instr, pc, valid         head instruction, its address, and its validity
//   ready                    CPU consumes the head when valid && ready
//   redirect, redirect_pc    fetch restart request and restart address
// ---------------------------------------------------------------------------
module instr_fetch
    import mps_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clock,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid,
    input  logic               ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] redirect_aligned;

    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              can_issue;
    logic              ack_kept;
    logic              bypass;

    assign redirect_aligned = word_align(redirect_pc);
    assign can_issue        = !fifo_full && (fifo_count < DEPTH_CNT);

    // A response is kept only when it answers a live request and no
    // redirect arrives in the same cycle.
    assign ack_kept = (state == FETCH_REQ) && mem_ack && !redirect;

`ifdef IFETCH_BYPASS_EN
    assign bypass = ack_kept && fifo_empty && ready;
`else
    assign bypass = 1'b0;
`endif

    assign push_entry = '{pc: fetch_pc, instr: mem_rdata};
    assign fifo_push  = ack_kept && !bypass;
    // Redirect acts as flush inside the FIFO and wins over this pop.
    assign fifo_pop   = ready && !fifo_empty;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign valid = !fifo_empty || bypass;
    assign instr = bypass ? mem_rdata : head_entry.instr;
    assign pc    = bypass ? fetch_pc  : head_entry.pc;

    // mem_req/mem_addr are registered and only change on entering REQ or on
    // the ack cycle, which keeps them stable for the life of a request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_aligned;
                    end else if (can_issue) begin
                        state    <= FETCH_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                FETCH_REQ: begin
                    if (mem_ack) begin
                        state    <= FETCH_IDLE;
                        mem_req  <= 1'b0;
                        fetch_pc <= redirect ? redirect_aligned : fetch_pc + 32'd4;
                    end else if (redirect) begin
                        state    <= FETCH_DRAIN;
                        fetch_pc <= redirect_aligned;
                    end
                end
                FETCH_DRAIN: begin
                    if (mem_ack) begin
                        state   <= FETCH_IDLE;
                        mem_req <= 1'b0;
                    end
                    if (redirect) fetch_pc <= redirect_aligned;
                end
                default: begin
                    state   <= FETCH_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch (default build, DEPTH = 4,
// RESET_PC = 0). The bench plays the instruction memory and the CPU. Its
// reference model is a queue of the (pc, instr) pairs the CPU should see,
// an expected next fetch address, and a record of the one outstanding
// request, updated from the externally visible rules of the fetch unit.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .pc          (pc),
        .valid       (valid),
        .ready       (ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          checks;
    int          passes;

    exp_t        q[$];
    logic [31:0] reqs[$];
    logic [31:0] pops[$];
    logic [31:0] model_pc;
    logic [31:0] req_addr;
    bit          outstanding;
    bit          stale;
    bit          ack_due;
    bit          last_req;
    bit          have_exp;
    bit          exp_req;
    int          wait_left;
    int          ack_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Asynchronous reset partway through a cycle; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset    = 1'b1;
        mem_ack  = 1'b0;
        redirect = 1'b0;
        ready    = 1'b0;
        #1;
        check("rst_mem_req",  mem_req,  0);
        check("rst_mem_addr", mem_addr, RPC);
        check("rst_valid",    valid,    0);
        check("rst_instr",    instr,    0);
        check("rst_pc",       pc,       0);
        repeat (2) @(negedge clock);
        reset       = 1'b0;
        q.delete();
        reqs.delete();
        pops.delete();
        model_pc    = RPC;
        outstanding = 1'b0;
        stale       = 1'b0;
        ack_due     = 1'b0;
        have_exp    = 1'b0;
        last_req    = 1'b0;
    endtask

    // Sample outputs mid-cycle and compare them with the model.
    task automatic observe();
        @(negedge clock);
        if (have_exp) check("issue", mem_req, exp_req);
        check("valid", valid, q.size() != 0);
        if (q.size() != 0) begin
            check("pc",    pc,    q[0].pc);
            check("instr", instr, q[0].instr);
        end
        if (outstanding) begin
            check("req_hold",  mem_req,  1);
            check("addr_hold", mem_addr, req_addr);
        end else if (mem_req) begin
            check("req_addr",     mem_addr,          model_pc);
            check("req_not_full", q.size() < DEPTH,  1);
            outstanding = 1'b1;
            stale       = 1'b0;
            req_addr    = model_pc;
            wait_left   = ack_lat;
            reqs.push_back(mem_addr);
        end
        ack_due  = outstanding && (wait_left == 0);
        last_req = mem_req;
    endtask

    // Drive this cycle's inputs and advance the model across the next edge.
    task automatic drive(input bit rdy, input bit rd, input logic [31:0] rpc);
        logic [31:0] data;
        data        = $urandom;
        ready       = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        mem_ack     = ack_due;
        mem_rdata   = data;
        // With nothing outstanding a request must follow unless full or redirected.
        have_exp = !last_req;
        exp_req  = !last_req && (q.size() < DEPTH) && !rd;
        if (rd) begin
            q.delete();
            model_pc = {rpc[31:2], 2'b00};
            if (outstanding) stale = 1'b1;
        end else if (rdy && q.size() != 0) begin
            pops.push_back(q[0].pc);
            void'(q.pop_front());
        end
        if (ack_due) begin
            outstanding = 1'b0;
            if (!rd && !stale) begin
                q.push_back(exp_t'{pc: req_addr, instr: data});
                model_pc = model_pc + 32'd4;
            end
        end else if (outstanding) begin
            wait_left--;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int np;
        int nr;
        int hits;
        bit found;

        checks      = 0;
        passes      = 0;
        reset       = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ack_lat     = 1;

        // Sequential fetch with ack one cycle after request, CPU always ready.
        do_reset();
        ack_lat = 1;
        repeat (16) begin
            observe();
            drive(1'b1, 1'b0, 32'h0);
        end
        check("seq_req0", reqs[0], 32'h0);
        check("seq_req1", reqs[1], 32'h4);
        check("seq_req2", reqs[2], 32'h8);
        check("seq_pop0", pops[0], 32'h0);
        check("seq_pop1", pops[1], 32'h4);
        check("seq_pop2", pops[2], 32'h8);

        // CPU stalled: four entries fill the FIFO, then fetch must stop.
        do_reset();
        ack_lat = 0;
        repeat (30) begin
            observe();
            drive(1'b0, 1'b0, 32'h0);
        end
        observe();
        check("full_no_req", mem_req, 0);
        check("full_valid",  valid,   1);
        nr = reqs.size();
        check("full_req_cnt", nr, DEPTH);
        drive(1'b1, 1'b0, 32'h0);
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            observe();
            found = (reqs.size() > nr);
            drive(1'b0, 1'b0, 32'h0);
        end
        check("refill_issued", found, 1);
        check("refill_addr", reqs[nr], 32'h10);

        // Redirect while the request for 8 waits three cycles for its ack.
        do_reset();
        ack_lat = 3;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            observe();
            found = outstanding && (req_addr == 32'h8);
            if (!found) drive(1'b1, 1'b0, 32'h0);
        end
        check("rd8_reached", found, 1);
        np = pops.size();
        nr = reqs.size();
        drive(1'b1, 1'b1, 32'h0000_0100);
        repeat (20) begin
            observe();
            drive(1'b1, 1'b0, 32'h0);
        end
        check("rd8_next_req", reqs[nr], 32'h100);
        check("rd8_first_pc", pops[np], 32'h100);

        // Redirect in the same cycle as the ack for address 12.
        do_reset();
        ack_lat = 1;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            observe();
            found = ack_due && (req_addr == 32'hC);
            if (!found) drive(1'b1, 1'b0, 32'h0);
        end
        check("rd12_reached", found, 1);
        nr = reqs.size();
        drive(1'b1, 1'b1, 32'h0000_0200);
        repeat (15) begin
            observe();
            drive(1'b1, 1'b0, 32'h0);
        end
        hits = 0;
        foreach (pops[i]) if (pops[i] == 32'hC) hits++;
        check("rd12_dropped",  hits,     0);
        check("rd12_next_req", reqs[nr], 32'h200);

        // Redirect near the top of memory, with low address bits set.
        do_reset();
        ack_lat = 0;
        observe();
        np = pops.size();
        drive(1'b1, 1'b1, 32'hFFFF_FFFB);
        repeat (20) begin
            observe();
            drive(1'b1, 1'b0, 32'h0);
        end
        check("wrap_pc0", pops[np],     32'hFFFF_FFF8);
        check("wrap_pc1", pops[np + 1], 32'hFFFF_FFFC);
        check("wrap_pc2", pops[np + 2], 32'h0000_0000);

        // Reset while a request is outstanding; fetch restarts at RESET_PC.
        ack_lat = 3;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            observe();
            found = outstanding;
            if (!found) drive(1'b1, 1'b0, 32'h0);
        end
        check("midreq_reached", found, 1);
        do_reset();
        ack_lat = 1;
        repeat (4) begin
            observe();
            drive(1'b1, 1'b0, 32'h0);
        end
        check("restart_addr", reqs[0], RPC);

        // Randomised traffic: ack latency, CPU readiness and redirects.
        for (int n = 0; n < 3000; n++) begin
            ack_lat = $urandom_range(0, 3);
            observe();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the prefetch FIFO entry count; legal values are powers of two, 2..16.
REQ-002 The parameter RESET_PC SHALL default to 32'h0000_0000 and set the first fetch address after reset.
REQ-003 The port clock SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-005 The port mem_req SHALL be an output, 1 bit wide, carrying the instruction memory read request.
REQ-006 The port mem_addr SHALL be an output, 32 bits wide, carrying the read address, word-aligned.
REQ-007 The port mem_ack SHALL be an input, 1 bit wide; the memory asserts it for one cycle when mem_rdata is valid.
REQ-008 The port mem_rdata SHALL be an input, 32 bits wide, carrying the read data.
REQ-009 The port instr SHALL be an output, 32 bits wide, carrying the instruction word at the FIFO head.
REQ-010 The port pc SHALL be an output, 32 bits wide, carrying the address of instr.
REQ-011 The port valid SHALL be an output, 1 bit wide; high means instr and pc are meaningful.
REQ-012 The port ready SHALL be an input, 1 bit wide; the CPU consumes the head when valid and ready are both high.
REQ-013 The port redirect SHALL be an input, 1 bit wide, requesting a fetch restart (jump or taken branch).
REQ-014 The port redirect_pc SHALL be an input, 32 bits wide, carrying the restart address, sampled when redirect is high.

Function
REQ-015 The FSM SHALL have three states: IDLE (no request outstanding), REQ (request outstanding, response wanted) and DRAIN (request outstanding, response to be discarded).
REQ-016 IDLE SHALL go to REQ when count + 0 < DEPTH and redirect is low; mem_req rises in the same cycle as REQ is entered, with mem_addr = fetch_pc.
REQ-017 mem_req and mem_addr SHALL stay stable from assertion until and including the mem_ack cycle; at most one request is outstanding.
REQ-018 In REQ, mem_ack SHALL push {fetch_pc, mem_rdata}, advance fetch_pc by 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), and go to IDLE.
REQ-019 In REQ or DRAIN, a redirect SHALL flush the FIFO, load fetch_pc from redirect_pc and go to DRAIN, unless mem_ack occurs in the same cycle, in which case the response is dropped and the FSM goes to IDLE.
REQ-020 In DRAIN, mem_ack SHALL discard mem_rdata and go to IDLE; fetch_pc is not advanced.
REQ-021 In IDLE, a redirect SHALL flush the FIFO and load fetch_pc; no request is issued that cycle.
REQ-022 A redirect in the same cycle as a pop SHALL take priority: the FIFO is empty the next cycle.
REQ-023 No request SHALL issue while the FIFO is full; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 The low two bits of redirect_pc SHALL be forced to zero.
REQ-025 valid SHALL equal FIFO not-empty; instr and pc SHALL come from the head register with no combinational path from ready.

Reset
REQ-026 Reset SHALL set state = IDLE, fetch_pc = RESET_PC, FIFO count = 0, mem_req = 0, mem_addr = RESET_PC, valid = 0, and instr and pc = 0.
REQ-027 Reset asserted while a request is outstanding SHALL abandon that request; a later mem_ack from it is not required to be tolerated.

Configuration
REQ-028 With IFETCH_BYPASS_EN defined, a response arriving in REQ while the FIFO is empty and ready is high SHALL appear on instr, pc and valid in the mem_ack cycle and be consumed without a FIFO write, giving zero-cycle latency.
REQ-029 Without IFETCH_BYPASS_EN, a response SHALL first become visible on valid in the cycle after mem_ack, and valid SHALL depend only on registered state.

Structure
REQ-030 The package mps_pkg SHALL hold the fetch state enum, INSTR_W = 32, ADDR_W = 32 and the default RESET_PC.
REQ-031 The FIFO SHALL be a sub-module fetch_fifo, parameterised by DEPTH and width, with push, pop, flush, full, empty and count.

Verification
REQ-032 Release reset with ack after 1 cycle and ready = 1: mem_addr SHALL go 0, 4, 8, and the outputs SHALL be pc = 0, 4, 8 with matching instr, with latency per REQ-028 and REQ-029.
REQ-033 Hold ready = 0 with DEPTH = 4: after four acks, mem_req SHALL stay low; raising ready SHALL pop one entry and reissue at address 16.
REQ-034 Redirect to 32'h0000_0100 with a request at address 8 outstanding and ack 3 cycles later: the data for address 8 SHALL be dropped, and the next request and the first valid pc SHALL be 0x100.
REQ-035 Redirect in the same cycle as the mem_ack for address 12: the data for address 12 SHALL never appear, and the next mem_addr SHALL be redirect_pc.
REQ-036 Redirect to 32'hFFFF_FFF8: fetched pcs SHALL be FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Assert reset mid-REQ: all outputs SHALL take their REQ-026 values immediately (asynchronous), and fetch SHALL restart at RESET_PC.
